// File: rtl/rxmac_ll8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rxmac_ll8_pkg
// Brief    : Shared constants for the RX MAC to LocalLink 8-bit bridge
// Revision : 1.0 - initial release
// ============================================================================
package rxmac_ll8_pkg;

  // FSM state encodings; also exported on the debug port
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_EOF_GOOD = 3'd2;
  localparam logic [2:0] ST_EOF_BAD  = 3'd3;
  localparam logic [2:0] ST_DROP     = 3'd4;

  // Default width of the good/dropped frame counters
  localparam int CNT_W_DEF = 16;

endpackage : rxmac_ll8_pkg
`default_nettype wire

// File: rtl/rxmac_to_ll8_if.sv
`default_nettype none
// ============================================================================
// Module   : rxmac_to_ll8_if
// Brief    : 8-bit LocalLink stream (data/sof/eof/error, src_rdy/dst_rdy)
// Revision : 1.0 - initial release
// ============================================================================
interface rxmac_to_ll8_if;
  logic [7:0] ll_data;
  logic       ll_sof;
  logic       ll_eof;
  logic       ll_error;
  logic       ll_src_rdy;
  logic       ll_dst_rdy;

  // Source side of the stream (the bridge)
  modport master (
    output ll_data, ll_sof, ll_eof, ll_error, ll_src_rdy,
    input  ll_dst_rdy
  );

  // Sink side of the stream (the RX frame FIFO)
  modport slave (
    input  ll_data, ll_sof, ll_eof, ll_error, ll_src_rdy,
    output ll_dst_rdy
  );
endinterface : rxmac_to_ll8_if
`default_nettype wire

// File: rtl/rx_stat_counter.sv
`default_nettype none
// ============================================================================
// Module   : rx_stat_counter
// Brief    : Saturating event counter with synchronous active-low reset
// Revision : 1.0 - initial release
// ============================================================================
module rx_stat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count events, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule : rx_stat_counter
`default_nettype wire

// File: rtl/rxmac_to_ll8.sv
`default_nettype none
// ============================================================================
// Module   : rxmac_to_ll8
// Brief    : Bridges the RX MAC byte stream onto an 8-bit LocalLink source.
//            One byte is held back so eof can be flagged on the last byte;
//            overruns terminate the frame with error and drop the remainder.
// Revision : 1.0 - initial release
// ============================================================================
module rxmac_to_ll8
  import rxmac_ll8_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_rx_ack,
  input  logic               i_rx_error,
  rxmac_to_ll8_if.master     ll,
  output logic [CNT_W-1:0]   o_frame_count,
  output logic [CNT_W-1:0]   o_drop_count,
  output logic [2:0]         o_debug
);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [7:0] r_hold_data;
  logic       r_hold_vld;
  logic       r_hold_first;
  logic       r_rx_valid_d;
  logic       r_collide;

  logic       w_start;
  logic       w_in_eof;
  logic       w_accept;
  logic       w_frame_inc;
  logic       w_drop_inc;

  assign w_start     = i_rx_valid & ~r_rx_valid_d;
  assign w_in_eof    = (r_state == ST_EOF_GOOD) | (r_state == ST_EOF_BAD);
  assign w_accept    = w_in_eof & ll.ll_dst_rdy;
  assign w_frame_inc = (r_state == ST_EOF_GOOD) & ll.ll_dst_rdy;
  // A frame that started while the eof beat was stalled is counted once,
  // at the moment the eof beat is finally accepted.
  assign w_drop_inc  = w_accept & ((r_state == ST_EOF_BAD) | r_collide | w_start);

  // State register
  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_RUN;
        end else if (i_rx_valid) begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_RUN: begin
        if (i_rx_error) begin
          w_state_nxt = ST_EOF_BAD;
        end else if (i_rx_valid) begin
          if (!ll.ll_dst_rdy) begin
            w_state_nxt = ST_EOF_BAD;
          end
        end else if (i_rx_ack) begin
          w_state_nxt = ST_EOF_GOOD;
        end else begin
          w_state_nxt = ST_EOF_BAD;
        end
      end
      ST_EOF_GOOD, ST_EOF_BAD: begin
        if (ll.ll_dst_rdy) begin
          w_state_nxt = i_rx_valid ? ST_DROP : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!i_rx_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // LocalLink outputs decoded from state and the holding register
  always_comb begin
    ll.ll_data    = r_hold_data;
    ll.ll_sof     = r_hold_first;
    ll.ll_eof     = 1'b0;
    ll.ll_error   = 1'b0;
    ll.ll_src_rdy = 1'b0;
    case (r_state)
      // The held byte goes out only when a following byte proves it is not
      // last; an rx_error cycle suppresses it so it is re-presented as the
      // error-terminated eof beat rather than delivered twice.
      ST_RUN:      ll.ll_src_rdy = r_hold_vld & i_rx_valid & ~i_rx_error;
      ST_EOF_GOOD: begin
        ll.ll_src_rdy = 1'b1;
        ll.ll_eof     = 1'b1;
      end
      ST_EOF_BAD:  begin
        ll.ll_src_rdy = 1'b1;
        ll.ll_eof     = 1'b1;
        ll.ll_error   = 1'b1;
      end
      default: ;
    endcase
  end

  // Holding register, rx_valid edge detect and collision tracking
  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_hold_data  <= 8'h00;
      r_hold_vld   <= 1'b0;
      r_hold_first <= 1'b0;
      r_rx_valid_d <= 1'b1;
      r_collide    <= 1'b0;
    end else begin
      r_rx_valid_d <= i_rx_valid;
      r_collide    <= w_in_eof & ~ll.ll_dst_rdy & (r_collide | w_start);
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_hold_data  <= i_rx_data;
            r_hold_vld   <= 1'b1;
            r_hold_first <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!i_rx_error && i_rx_valid && ll.ll_dst_rdy) begin
            r_hold_data  <= i_rx_data;
            r_hold_first <= 1'b0;
          end
        end
        ST_EOF_GOOD, ST_EOF_BAD: begin
          if (ll.ll_dst_rdy) begin
            r_hold_vld   <= 1'b0;
            r_hold_first <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  rx_stat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_frame_inc),
    .o_count (o_frame_count)
  );

  rx_stat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_drop_inc),
    .o_count (o_drop_count)
  );

  assign o_debug = r_state;

endmodule : rxmac_to_ll8
`default_nettype wire

// File: tb/tb_rxmac_to_ll8.sv
`default_nettype none
// ============================================================================
// Module   : tb_rxmac_to_ll8
// Brief    : Directed self-checking bench for rxmac_to_ll8
// Revision : 1.0 - initial release
// ============================================================================
module tb_rxmac_to_ll8;
  import rxmac_ll8_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_clear;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack;
  logic        rx_error;
  logic [15:0] frame_count;
  logic [15:0] drop_count;
  logic [2:0]  debug;

  rxmac_to_ll8_if u_if ();

  rxmac_to_ll8 #(.CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (i_clear),
    .i_rx_data     (rx_data),
    .i_rx_valid    (rx_valid),
    .i_rx_ack      (rx_ack),
    .i_rx_error    (rx_error),
    .ll            (u_if),
    .o_frame_count (frame_count),
    .o_drop_count  (drop_count),
    .o_debug       (debug)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted beats: {error, eof, sof, data}
  logic [10:0] beats[$];
  int          beat_cyc[$];
  logic [10:0] exp_q[$];
  logic [7:0]  fb[16];

  always @(negedge clk) begin
    if (u_if.ll_src_rdy && u_if.ll_dst_rdy) begin
      beats.push_back({u_if.ll_error, u_if.ll_eof, u_if.ll_sof, u_if.ll_data});
      beat_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_beats(input string tag);
    chk($sformatf("%s_nbeats", tag), beats.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < beats.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), {21'd0, beats[i]}, {21'd0, exp_q[i]});
    beats.delete();
    beat_cyc.delete();
    exp_q.delete();
  endtask

  // Drive one frame from fb[]; endk 0=rx_ack, 1=rx_error.
  // stall >= 0 drops ll_dst_rdy for the cycle carrying byte index stall.
  task automatic send_frame(input int n, input int stall, input int endk,
                            output int c_first, output int c_last);
    c_first = 0;
    c_last  = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx_valid        = 1'b1;
      rx_data         = fb[i];
      u_if.ll_dst_rdy = (i == stall) ? 1'b0 : 1'b1;
      if (i == 0)     c_first = cyc;
      if (i == n - 1) c_last  = cyc;
      if (stall >= 0 && i == stall + 3) begin
        @(negedge clk);
        chk("overrun_drop_state", {29'd0, debug}, {29'd0, ST_DROP});
      end
    end
    @(posedge clk); #1;
    rx_valid        = 1'b0;
    rx_data         = 8'h00;
    u_if.ll_dst_rdy = 1'b1;
    rx_ack          = (endk == 0);
    rx_error        = (endk == 1);
    @(posedge clk); #1;
    rx_ack   = 1'b0;
    rx_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  int cf, cl;

  initial begin
    reset = 1'b0; i_clear = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0; rx_ack = 1'b0; rx_error = 1'b0;
    u_if.ll_dst_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_debug",   {29'd0, debug}, 32'd0);
    chk("rst_src_rdy", {31'd0, u_if.ll_src_rdy}, 32'd0);
    chk("rst_sof_eof_err", {29'd0, u_if.ll_sof, u_if.ll_eof, u_if.ll_error}, 32'd0);
    chk("rst_data",    {24'd0, u_if.ll_data}, 32'd0);
    chk("rst_counts",  {frame_count, drop_count}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 4-byte good frame
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
    exp_q = '{11'h111, 11'h022, 11'h033, 11'h244};
    send_frame(4, -1, 0, cf, cl);
    if (beat_cyc.size() == 4) begin
      chk("f4_lat_first", beat_cyc[0] - cf, 32'd1);
      chk("f4_lat_last",  beat_cyc[3] - cl, 32'd2);
    end
    check_beats("f4");
    chk("f4_frame_cnt", {16'd0, frame_count}, 32'd1);
    chk("f4_drop_cnt",  {16'd0, drop_count},  32'd0);

    // single-byte frame
    fb[0] = 8'hA5;
    exp_q = '{11'h3A5};
    send_frame(1, -1, 0, cf, cl);
    check_beats("f1");
    chk("f1_frame_cnt", {16'd0, frame_count}, 32'd2);

    // 10-byte frame with overrun at byte 5
    for (int i = 0; i < 10; i++) fb[i] = 8'h31 + 8'(i);
    exp_q = '{11'h131, 11'h032, 11'h033, 11'h634};
    send_frame(10, 4, 0, cf, cl);
    check_beats("ovr");
    chk("ovr_idle",      {29'd0, debug}, {29'd0, ST_IDLE});
    chk("ovr_drop_cnt",  {16'd0, drop_count},  32'd1);
    chk("ovr_frame_cnt", {16'd0, frame_count}, 32'd2);

    // 6-byte frame ended by rx_error
    for (int i = 0; i < 6; i++) fb[i] = 8'h41 + 8'(i);
    exp_q = '{11'h141, 11'h042, 11'h043, 11'h044, 11'h045, 11'h646};
    send_frame(6, -1, 1, cf, cl);
    check_beats("ferr");
    chk("ferr_drop_cnt",  {16'd0, drop_count},  32'd2);
    chk("ferr_frame_cnt", {16'd0, frame_count}, 32'd2);

    // reset released mid-frame, then a good 3-byte frame
    reset = 1'b0; rx_valid = 1'b1; rx_data = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_drop_state", {29'd0, debug}, {29'd0, ST_DROP});
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_counts", {frame_count, drop_count}, 32'd0);
    fb[0] = 8'h51; fb[1] = 8'h52; fb[2] = 8'h53;
    exp_q = '{11'h151, 11'h052, 11'h253};
    send_frame(3, -1, 0, cf, cl);
    check_beats("mid");
    chk("mid_frame_cnt", {16'd0, frame_count}, 32'd1);
    chk("mid_drop_cnt",  {16'd0, drop_count},  32'd0);

    // eof beat stalled while a new frame starts
    exp_q = '{11'h161, 11'h262};
    @(posedge clk); #1; rx_valid = 1'b1; rx_data = 8'h61; u_if.ll_dst_rdy = 1'b1;
    @(posedge clk); #1; rx_data = 8'h62;
    @(posedge clk); #1; rx_valid = 1'b0; rx_ack = 1'b1; u_if.ll_dst_rdy = 1'b0;
    @(posedge clk); #1; rx_ack = 1'b0;
    @(negedge clk);
    chk("col_eof_good", {29'd0, debug}, {29'd0, ST_EOF_GOOD});
    chk("col_eof_flag", {31'd0, u_if.ll_eof}, 32'd1);
    @(posedge clk); #1; rx_valid = 1'b1; rx_data = 8'h71;
    @(posedge clk); #1; rx_data = 8'h72; u_if.ll_dst_rdy = 1'b1;
    @(posedge clk); #1; rx_data = 8'h73;
    @(negedge clk);
    chk("col_drop_state", {29'd0, debug}, {29'd0, ST_DROP});
    @(posedge clk); #1; rx_valid = 1'b0; rx_ack = 1'b1;
    @(posedge clk); #1; rx_ack = 1'b0;
    @(negedge clk);
    chk("col_idle", {29'd0, debug}, {29'd0, ST_IDLE});
    repeat (2) @(posedge clk);
    #1;
    check_beats("col");
    chk("col_frame_cnt", {16'd0, frame_count}, 32'd2);
    chk("col_drop_cnt",  {16'd0, drop_count},  32'd1);

    // soft clear mid-frame: counters hold, rest of frame dropped
    @(posedge clk); #1; rx_valid = 1'b1; rx_data = 8'h81; u_if.ll_dst_rdy = 1'b0;
    @(posedge clk); #1; rx_data = 8'h82; i_clear = 1'b1;
    @(posedge clk); #1; rx_data = 8'h83; i_clear = 1'b0; u_if.ll_dst_rdy = 1'b1;
    @(posedge clk); #1; rx_data = 8'h84;
    @(negedge clk);
    chk("clr_drop_state", {29'd0, debug}, {29'd0, ST_DROP});
    @(posedge clk); #1; rx_valid = 1'b0; rx_ack = 1'b1;
    @(posedge clk); #1; rx_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_beats("clr");
    chk("clr_counts", {frame_count, drop_count}, {16'd2, 16'd1});
    chk("clr_idle",   {29'd0, debug}, {29'd0, ST_IDLE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rxmac_to_ll8
`default_nettype wire

// File: doc/rxmac_to_ll8.md
Name: rxmac_to_ll8

Overview:
- Receive-side counterpart of the LocalLink-to-TX-MAC bridge.
- Converts the 8-bit RX MAC byte stream (rx_data/rx_valid plus end-of-frame rx_ack/rx_error strobes) into an 8-bit LocalLink source stream (data/sof/eof/error with src_rdy/dst_rdy handshake).
- The MAC cannot be back-pressured, so overruns are detected, the frame is terminated with error, and the remainder of that MAC frame is discarded.
- Sits between the Ethernet RX MAC and the RX frame FIFO; provides good/dropped frame counters.

Parameters:
CNT_W, 16, width of the good-frame and dropped-frame counters (saturating).

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
clear  in  1  synchronous soft clear, active high; resets FSM and holding register, not counters
rx_data  in  8  MAC receive byte
rx_valid  in  1  rx_data valid; high for contiguous bytes of one frame
rx_ack  in  1  one-cycle strobe in the cycle after the last byte: frame good
rx_error  in  1  one-cycle strobe: frame bad (FCS, PHY error); may occur any cycle after frame start
ll_data  out  8  LocalLink data
ll_sof  out  1  first byte of frame
ll_eof  out  1  last byte of frame
ll_error  out  1  qualifies ll_eof: frame bad or truncated
ll_src_rdy  out  1  output byte valid
ll_dst_rdy  in  1  downstream accepts; transfer = ll_src_rdy & ll_dst_rdy
frame_count  out  CNT_W  good frames delivered (eof without error accepted)
drop_count  out  CNT_W  frames ended with error or discarded
debug  out  3  current FSM state encoding

Behaviour:
- Reset (reset==0) values: state IDLE; hold_vld 0; ll_data 0; ll_sof/ll_eof/ll_error/ll_src_rdy 0; counters 0; rx_valid_d 1.
- clear==1 gives the same values except counters, which hold.
- Holding register: hold_data, hold_vld, hold_first. The held byte is emitted only once it is known not to be last (next byte arriving) or once the frame end is known.
- rx_valid_d is rx_valid registered. A frame start is rx_valid & !rx_valid_d.
- ll_data = hold_data; ll_sof = hold_first; ll_eof/ll_error are driven from state as given below. All outputs are combinational from registers, except ll_src_rdy in RUN.
- States, debug encoding: IDLE=0, RUN=1, EOF_GOOD=2, EOF_BAD=3, DROP=4.
- IDLE:
  - ll_src_rdy=0.
  - On frame start: capture byte, hold_vld=1, hold_first=1, go RUN.
  - On rx_valid & rx_valid_d (mid-frame after reset/clear): go DROP, no count.
- RUN:
  - ll_src_rdy = hold_vld & rx_valid.
  - rx_valid & ll_dst_rdy: held byte transfers; new byte loaded; hold_first=0.
  - rx_valid & !ll_dst_rdy (overrun): new byte lost; go EOF_BAD.
  - rx_error (any cycle): go EOF_BAD; a byte on rx_data that cycle is discarded.
  - !rx_valid & rx_ack: go EOF_GOOD.
  - !rx_valid with neither strobe: go EOF_BAD.
- EOF_GOOD / EOF_BAD:
  - ll_src_rdy=1, ll_eof=1, ll_error=(state==EOF_BAD); held byte presented until accepted.
  - On acceptance: EOF_GOOD increments frame_count; EOF_BAD increments drop_count; hold_vld=0.
  - Next state after acceptance: DROP if rx_valid==1 (rest of this frame, or a new frame that collided), else IDLE.
  - A new frame start while waiting for acceptance increments drop_count once, at acceptance.
- DROP: ll_src_rdy=0; all rx input ignored; go IDLE when rx_valid==0.
- Latency and edge cases:
  - Byte N appears on LocalLink one cycle after it is on rx_data; the last byte appears 2 cycles after it.
  - Single-byte frame: ll_sof=ll_eof=1 on one beat.
  - rx_ack and rx_error together: rx_error wins.
- Counters saturate at 2^CNT_W-1; no wrap.

Decomposition:
- Package rxmac_ll8_pkg: state encodings (ST_IDLE..ST_DROP, 3-bit), default CNT_W.
- One sub-module: rx_stat_counter (CNT_W saturating counter with inc and synchronous active-low reset), instantiated twice.

Test Plan:
- 4-byte frame 0x11,0x22,0x33,0x44, rx_ack after last, ll_dst_rdy=1 -> four beats:
  - sof on 0x11, eof on 0x44, error=0;
  - 0x44 beat two cycles after its rx cycle;
  - frame_count=1.
- 1-byte frame 0xA5 with rx_ack -> single beat with sof=eof=1, error=0, data 0xA5.
- 10-byte frame, ll_dst_rdy=0 at byte 5 -> eof+error on held byte 4, no further beats, drop_count=1, state DROP then IDLE when rx_valid falls.
- 6-byte frame, rx_error instead of rx_ack -> bytes 1-5 delivered, byte 6 with eof+error=1, drop_count=1, frame_count=0.
- Reset released with rx_valid high mid-frame, then full 3-byte frame with ack -> first frame fully discarded (no beats, no count), second delivered, frame_count=1.
- EOF_GOOD held with ll_dst_rdy=0 while new frame starts, then ll_dst_rdy=1 -> eof beat accepted, frame_count=1, drop_count=1, new frame discarded, IDLE after rx_valid low.
